clk_gate_ctrl: RTL

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl_pkg.sv | 17 +
 rtl/clk_gate_dom_fsm.sv | 116 +++++++++++
 rtl/clk_gate_ctrl.sv | 43 ++++
 3 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and default parameters for the clock-gating controller.
// Holds the per-domain FSM state encoding and the default sizing constants
// used by clk_gate_ctrl and clk_gate_dom_fsm.
package clk_gate_ctrl_pkg;

  localparam int DEF_NUM_DOM  = 4;
  localparam int DEF_IDLE_W   = 8;
  localparam int DEF_WAKE_CYC = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } dom_state_t;

endpackage

// File: rtl/clk_gate_dom_fsm.sv
// Single-domain clock-gating FSM (RUN -> COUNT -> GATED -> WAKE -> RUN) with idle/settle counter.
// Latency: all outputs registered; they change on the same edge as the state transition.
// Backpressure: wake_req is a level held by the requester until o_wake_ack; no other flow control.
// Ports: i_clk/i_rst (sync active-high), i_test_mode, i_idle_thresh, i_gate_permit,
//        i_busy, i_wake_req -> o_wake_ack, o_gate_en, o_gated.
module clk_gate_dom_fsm
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_W   = DEF_IDLE_W,
  parameter int WAKE_CYC = DEF_WAKE_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_test_mode,
  input  logic [IDLE_W-1:0] i_idle_thresh,
  input  logic              i_gate_permit,
  input  logic              i_busy,
  input  logic              i_wake_req,
  output logic              o_wake_ack,
  output logic              o_gate_en,
  output logic              o_gated
);

  // Counter value on the last settle cycle of WAKE.
  localparam logic [IDLE_W-1:0] WAKE_LAST = IDLE_W'(WAKE_CYC - 1);

  dom_state_t        r_state;
  dom_state_t        w_state_nxt;
  logic [IDLE_W-1:0] r_cnt;
  logic [IDLE_W-1:0] w_cnt_nxt;
  logic              r_gate_en;
  logic              r_gated;
  logic              r_wake_ack;
  logic              w_gate_en_nxt;
  logic              w_gated_nxt;
  logic              w_wake_ack_nxt;

  logic              w_idle_ok;
  logic              w_wake_trig;
  logic [IDLE_W-1:0] w_thresh_last;

  // Idle qualifies only with no activity, no request, no test override and a
  // non-zero threshold; any of those failing aborts counting before gating.
  assign w_idle_ok     = i_gate_permit & ~i_busy & ~i_wake_req & ~i_test_mode &
                         (i_idle_thresh != '0);
  assign w_wake_trig   = i_wake_req | i_busy | i_test_mode | ~i_gate_permit;
  // Only consulted when the threshold is non-zero, so no underflow matters.
  assign w_thresh_last = i_idle_thresh - IDLE_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_idle_ok) begin
          w_state_nxt = ST_COUNT;
          w_cnt_nxt   = '0;
        end
      end
      ST_COUNT: begin
        if (!w_idle_ok) begin
          w_state_nxt = ST_RUN;
        end else if (r_cnt >= w_thresh_last) begin
          // Live compare: a threshold lowered below the count gates next edge.
          w_state_nxt = ST_GATED;
        end else begin
          w_cnt_nxt = r_cnt + IDLE_W'(1);
        end
      end
      ST_GATED: begin
        if (w_wake_trig) begin
          w_state_nxt = ST_WAKE;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAKE: begin
        // Fixed settle time; nothing can shorten it.
        if (r_cnt >= WAKE_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + IDLE_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase

    // Outputs follow the next state so they update with the transition edge.
    w_gate_en_nxt  = (w_state_nxt != ST_GATED);
    w_gated_nxt    = (w_state_nxt == ST_GATED);
    w_wake_ack_nxt = (w_state_nxt == ST_RUN) & i_wake_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_gate_en  <= 1'b1;
      r_gated    <= 1'b0;
      r_wake_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gate_en  <= w_gate_en_nxt;
      r_gated    <= w_gated_nxt;
      r_wake_ack <= w_wake_ack_nxt;
    end
  end

  assign o_gate_en  = r_gate_en;
  assign o_gated    = r_gated;
  assign o_wake_ack = r_wake_ack;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-domain clock-gating controller: one independent FSM per domain, shared config fanned out.
// Latency: outputs registered, updating on the edge of the causing transition.
// Backpressure: per-domain level wake_req held until wake_ack; no other flow control.
// Ports: clk_in, rst (sync active-high), test_mode, cfg_idle_thresh, cfg_gate_en,
//        dom_busy, wake_req -> wake_ack, gate_en, dom_gated (all NUM_DOM wide).
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int NUM_DOM  = DEF_NUM_DOM,
  parameter int IDLE_W   = DEF_IDLE_W,
  parameter int WAKE_CYC = DEF_WAKE_CYC
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               test_mode,
  input  logic [IDLE_W-1:0]  cfg_idle_thresh,
  input  logic [NUM_DOM-1:0] cfg_gate_en,
  input  logic [NUM_DOM-1:0] dom_busy,
  input  logic [NUM_DOM-1:0] wake_req,
  output logic [NUM_DOM-1:0] wake_ack,
  output logic [NUM_DOM-1:0] gate_en,
  output logic [NUM_DOM-1:0] dom_gated
);

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    clk_gate_dom_fsm #(
      .IDLE_W   (IDLE_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_dom (
      .i_clk         (clk_in),
      .i_rst         (rst),
      .i_test_mode   (test_mode),
      .i_idle_thresh (cfg_idle_thresh),
      .i_gate_permit (cfg_gate_en[g]),
      .i_busy        (dom_busy[g]),
      .i_wake_req    (wake_req[g]),
      .o_wake_ack    (wake_ack[g]),
      .o_gate_en     (gate_en[g]),
      .o_gated       (dom_gated[g])
    );
  end

endmodule
